// File: rtl/modmul_driver_if.sv
// Signal bundle between the modular-multiplier driver, its job source/sink and one multiplier.
// master = driver side, slave = environment (scheduler, consumer and multiplier).
interface modmul_driver_if #(
  parameter int unsigned P_WIDTH   = 256,
  parameter int unsigned TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [P_WIDTH-1:0]   in_a;
  logic [P_WIDTH-1:0]   in_b;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   out_r;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_timeout;
  logic                 busy;

  logic                 mm_reset;
  logic                 mm_enable;
  logic [P_WIDTH-1:0]   mm_a;
  logic [P_WIDTH-1:0]   mm_b;
  logic [P_WIDTH-1:0]   mm_r;
  logic                 mm_done;

  modport master (
    input  in_valid, in_a, in_b, in_tag, out_ready, mm_r, mm_done,
    output in_ready, out_valid, out_r, out_tag, out_timeout, busy,
    output mm_reset, mm_enable, mm_a, mm_b
  );

  modport slave (
    output in_valid, in_a, in_b, in_tag, out_ready, mm_r, mm_done,
    input  in_ready, out_valid, out_r, out_tag, out_timeout, busy,
    input  mm_reset, mm_enable, mm_a, mm_b
  );
endinterface

// File: rtl/modmul_driver.sv
// Initiator-side controller for one modular multiplier: accepts a job, resets and runs the unit,
// captures the result (or a watchdog abort) and returns it with its tag.
module modmul_driver #(
  parameter int unsigned P_WIDTH        = 256,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  modmul_driver_if.master  bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StHold} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CntW-1:0]      r_cnt;
  logic [P_WIDTH-1:0]   r_mm_a;
  logic [P_WIDTH-1:0]   r_mm_b;
  logic [P_WIDTH-1:0]   r_out_r;
  logic [TAG_WIDTH-1:0] r_out_tag;
  logic                 r_out_timeout;

  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_mm_reset;
  logic                 w_mm_enable;
  logic                 w_expired;

  assign w_expired = (r_cnt == CntLast);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (bus.in_valid) w_state_nxt = StClear;
      StClear: w_state_nxt = StRun;
      StRun:   if (bus.mm_done || w_expired) w_state_nxt = StHold;
      StHold:  if (bus.out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Control outputs decoded from state only; the unit is held in reset outside RUN
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_mm_reset  = 1'b1;
    w_mm_enable = 1'b0;
    unique case (r_state)
      StIdle:  w_in_ready = 1'b1;
      StRun: begin
        w_mm_reset  = 1'b0;
        w_mm_enable = 1'b1;
      end
      StHold:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands change only on acceptance, results only on leaving RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_mm_a        <= '0;
      r_mm_b        <= '0;
      r_out_r       <= '0;
      r_out_tag     <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_mm_a    <= bus.in_a;
            r_mm_b    <= bus.in_b;
            r_out_tag <= bus.in_tag;
            r_cnt     <= '0;
          end
        end
        StRun: begin
          // A done in the final watchdog cycle still counts as a completed job
          if (bus.mm_done) begin
            r_out_r       <= bus.mm_r;
            r_out_timeout <= 1'b0;
          end else if (w_expired) begin
            r_out_r       <= '0;
            r_out_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_r       = r_out_r;
  assign bus.out_tag     = r_out_tag;
  assign bus.out_timeout = r_out_timeout;
  assign bus.busy        = (r_state != StIdle);
  assign bus.mm_reset    = w_mm_reset;
  assign bus.mm_enable   = w_mm_enable;
  assign bus.mm_a        = r_mm_a;
  assign bus.mm_b        = r_mm_b;

endmodule
